// File: rtl/reg_file_mp.sv
// Multi-port integer register file with x0 hard-wired to zero and a per-register
// pending-write counter that drives RAW busy flags for the issue stage.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int CW     = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                flush
);

    localparam int NW = $clog2(NWR + 1);
    localparam int SW = CW + NW;

    logic [XLEN-1:0] rf_reg   [NREGS];
    logic [CW-1:0]   cnt_reg  [NREGS];
    logic [CW-1:0]   cnt_dec  [NREGS];
    logic [CW-1:0]   cnt_next [NREGS];
    logic [NW-1:0]   n_wr     [NREGS];
    logic            iss_hit  [NREGS];

    // A same-cycle writeback deliberately does not raise iss_ready.
    assign iss_ready = (iss_addr == '0) || (cnt_reg[iss_addr] != {CW{1'b1}});

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            n_wr[r] = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r)))
                    n_wr[r] = n_wr[r] + NW'(1);
            end
            cnt_dec[r] = (SW'(cnt_reg[r]) > SW'(n_wr[r])) ?
                         CW'(SW'(cnt_reg[r]) - SW'(n_wr[r])) : '0;
            iss_hit[r] = iss_en && iss_ready && (iss_addr == AW'(r)) && (r != 0);
            if (r == 0)
                cnt_next[r] = '0;
            else if (flush)
                cnt_next[r] = CW'(iss_hit[r]);
            else
                cnt_next[r] = cnt_dec[r] + CW'(iss_hit[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_reg[r]  <= '0;
                cnt_reg[r] <= '0;
            end
        end else begin
            // Ascending port order so the highest-index port wins a conflict.
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
                    rf_reg[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
            end
            for (int r = 0; r < NREGS; r++)
                cnt_reg[r] <= cnt_next[r];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            busy;

            assign addr = rd_addr[gi*AW +: AW];

            always_comb begin
                data = rf_reg[addr];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_en[k] && (wr_addr[k*AW +: AW] == addr))
                            data = wr_data[k*XLEN +: XLEN];
                    end
                end
                if (addr == '0)
                    data = '0;
                if (BYPASS != 0)
                    busy = (addr != '0) && (cnt_dec[addr] != '0);
                else
                    busy = (addr != '0) && (cnt_reg[addr] != '0);
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
            assign rd_busy[gi]              = busy;
        end
    endgenerate

endmodule
